// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI channel arbiter.
//   state_t      : arbiter FSM encoding (3-bit, codes 6..7 unused)
//   REQ_*        : requester slot indices
//   DEF_TIMEOUT  : default watchdog limit in clkin_50m cycles
//   ptr_width()  : width of an index into NREQ requesters (at least 1)
package oled_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    WAIT = 3'd2,
    ACK  = 3'd3,
    HOLD = 3'd4,
    REL  = 3'd5
  } state_t;

  localparam int REQ_INIT    = 0;
  localparam int REQ_CLEAR   = 1;
  localparam int REQ_WRITE   = 2;

  localparam int DEF_TIMEOUT = 100000;
  localparam int DEF_TW      = 17;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oled_rr_pick.sv
// Combinational winner selection among the OLED requesters.
//   req        in  NREQ  pending requests
//   ptr        in  PW    round-robin start index (ignored when FIXED_PRIO=1)
//   win        out NREQ  one-hot winner, zero when no request
//   valid      out 1     at least one request pending
module oled_rr_pick
  import oled_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int PW         = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            valid
);

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] masked;

  // Round-robin as two priority passes: first look only at indices at or
  // above ptr; if none of those request, wrap and take the lowest overall.
  // x & (~x + 1) isolates the lowest set bit.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked = FIXED_PRIO ? '0 : (req & mask);
    if (|masked) win = masked & (~masked + NREQ'(1));
    else         win = req & (~req + NREQ'(1));
  end

  assign valid = |req;

endmodule

// File: rtl/oled_spi_arbiter.sv
// Shares one spi_master byte channel among NREQ OLED requesters
// (init, clear, per-digit write). A grant is held for a whole burst.
//   clkin_50m      in   system clock
//   reset          in   synchronous, active-high
//   req/last/req_dc in  NREQ per-requester request, end-of-burst, D/C
//   req_data       in   8*NREQ bytes, requester i at [8i+7:8i]
//   ack            out  NREQ one-cycle byte-done pulse
//   grant          out  NREQ one-hot channel owner
//   spi_send       out  start pulse to spi_master
//   spi_data_out   out  byte to spi_master
//   dc_out         out  D/C to spi_master
//   spi_send_done  in   completion level from spi_master
//   busy           out  channel owned
//   err_timeout    out  sticky watchdog flag
//
// state | meaning
// IDLE  | channel free, arbitrate among requests
// SEND  | pulse spi_send (stalls while previous done still high)
// WAIT  | waiting for rising edge of spi_send_done
// ACK   | ack pulse to the owner
// HOLD  | mid-burst, waiting for the owner's next byte
// REL   | drop grant, advance round-robin pointer
module oled_spi_arbiter
  import oled_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int TW         = DEF_TW
) (
  input  logic              clkin_50m,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   last,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_dc,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  output logic              spi_send,
  output logic [7:0]        spi_data_out,
  output logic              dc_out,
  input  logic              spi_send_done,
  output logic              busy,
  output logic              err_timeout
);

  localparam int PW = ptr_width(NREQ);

  state_t          state, state_n;
  logic [NREQ-1:0] grant_n, win, sel;
  logic [PW-1:0]   ptr, ptr_n, gidx, ptr_next;
  logic [TW-1:0]   cnt, cnt_n, cnt_inc;
  logic [7:0]      data_n, sel_data;
  logic            dc_n, sel_dc, last_q, last_n, sel_last;
  logic            err_n, win_valid, done_q, done_rise, load;

  oled_rr_pick #(
    .NREQ       (NREQ),
    .FIXED_PRIO (FIXED_PRIO),
    .PW         (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .win   (win),
    .valid (win_valid)
  );

  assign done_rise = spi_send_done & ~done_q;
  assign cnt_inc   = cnt + TW'(1);
  assign busy      = |grant;

  // In IDLE the byte is taken from the winner so it is already on
  // spi_data_out during the SEND cycle; afterwards from the owner.
  always_comb begin
    sel      = (state == IDLE) ? win : grant;
    sel_data = '0;
    sel_dc   = 1'b0;
    sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel[i]) begin
        sel_data = req_data[8*i +: 8];
        sel_dc   = req_dc[i];
        sel_last = last[i];
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
    ptr_next = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
  end

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    ptr_n    = ptr;
    cnt_n    = cnt;
    err_n    = err_timeout;
    spi_send = 1'b0;
    ack      = '0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          grant_n = win;
          load    = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        load = 1'b1;
        if (!done_q) begin
          spi_send = 1'b1;
          cnt_n    = '0;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (done_rise) begin
          state_n = ACK;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == TW'(TIMEOUT)) begin
            err_n   = 1'b1;
            state_n = REL;
          end
        end
      end
      ACK: begin
        ack = grant;
        if (last_q) begin
          state_n = REL;
        end else begin
          cnt_n   = '0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (|(req & grant)) begin
          load    = 1'b1;
          state_n = SEND;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == TW'(TIMEOUT)) begin
            err_n   = 1'b1;
            state_n = REL;
          end
        end
      end
      REL: begin
        grant_n = '0;
        if (|grant) ptr_n = ptr_next;
        state_n = IDLE;
      end
      default: state_n = REL;
    endcase
  end

  always_comb begin
    data_n = spi_data_out;
    dc_n   = dc_out;
    last_n = last_q;
    if (load) begin
      data_n = sel_data;
      dc_n   = sel_dc;
      last_n = sel_last;
    end
  end

  always_ff @(posedge clkin_50m) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      ptr          <= '0;
      cnt          <= '0;
      done_q       <= 1'b0;
      spi_data_out <= '0;
      dc_out       <= 1'b0;
      last_q       <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_n;
      grant        <= grant_n;
      ptr          <= ptr_n;
      cnt          <= cnt_n;
      done_q       <= spi_send_done;
      spi_data_out <= data_n;
      dc_out       <= dc_n;
      last_q       <= last_n;
      err_timeout  <= err_n;
    end
  end

endmodule
